// File: rtl/s_p_buffer_if.sv
// Serial-in / parallel-out frame buffer bus: element stream in, assembled frame out.
// Combinational path: none (signal bundle only).
// Backpressure: in_ready qualifies in_valid; an element moves only when both are high.
interface s_p_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 13
);
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    in_ready;
    logic [DEPTH*DATA_W-1:0] par_data;
    logic                    s_p_flag;
    logic [3:0]              count;

    modport master (
        output in_valid, in_data,
        input  in_ready, par_data, s_p_flag, count
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, par_data, s_p_flag, count
    );
endinterface

// File: rtl/s_p_buffer.sv
// Collects DEPTH serial elements into one parallel frame, pulses s_p_flag, then holds the frame.
// Latency: s_p_flag is high the cycle after the DEPTH-th accept; par_data updates on each accept edge.
// Backpressure: in_ready drops for 1+HOLD_CYCLES cycles after a frame completes; in_valid is ignored then.
module s_p_buffer #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 13,
    parameter int HOLD_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst,
    s_p_buffer_if.slave    bus
);
    localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [3:0]      LAST_IDX  = 4'(DEPTH - 1);
    localparam logic [3:0]      FULL_CNT  = 4'(DEPTH);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FLAG = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              count_q;
    logic [HW-1:0]           hold_cnt;
    logic [DEPTH*DATA_W-1:0] par_q;
    logic                    flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            count_q  <= 4'd0;
            hold_cnt <= '0;
            par_q    <= '0;
            flag_q   <= 1'b0;
        end else begin
            flag_q <= 1'b0;
            case (state)
                FILL: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (count_q == 4'(k)) begin
                                par_q[k*DATA_W +: DATA_W] <= bus.in_data;
                            end
                        end
                        count_q <= count_q + 4'd1;
                        if (count_q == LAST_IDX) begin
                            state  <= FLAG;
                            flag_q <= 1'b1;
                        end
                    end
                end
                FLAG: begin
                    state    <= HOLD;
                    hold_cnt <= HOLD_LOAD;
                end
                HOLD: begin
                    // count stays at DEPTH so the controller can still read a full frame
                    if (hold_cnt == '0) begin
                        state   <= FILL;
                        count_q <= 4'd0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= FILL;
                    count_q  <= 4'd0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready = (state == FILL);
    assign bus.par_data = par_q;
    assign bus.s_p_flag = flag_q;
    assign bus.count    = count_q;

    // FULL_CNT documents the count value held through FLAG/HOLD; unused in logic otherwise
    logic unused_full;
    assign unused_full = (count_q == FULL_CNT);
endmodule

// File: tb/tb_s_p_buffer.sv
// Directed bench for s_p_buffer: reset, full frame, gapped input, hold backpressure,
// mid-frame reset and back-to-back frames, checked with immediate assertions.
module tb_s_p_buffer;
    localparam int DW = 8;
    localparam int DP = 13;
    localparam int HC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    s_p_buffer_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

    s_p_buffer #(.DATA_W(DW), .DEPTH(DP), .HOLD_CYCLES(HC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int flag_cnt  = 0;
    int last_flag = -1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.s_p_flag === 1'b1) begin
            flag_cnt++;
            last_flag = cyc;
        end
    endtask

    function automatic logic [DP*DW-1:0] frame(input logic [7:0] base);
        logic [DP*DW-1:0] f;
        f = '0;
        for (int k = 0; k < DP; k++) f[k*DW +: DW] = base + 8'(k);
        return f;
    endfunction

    initial begin
        int low;
        int guard;
        int start;
        int f1;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        step(0, 8'h00);
        step(0, 8'h00);
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_flag",     bus.s_p_flag, 0);
        chk("rst_count",    bus.count, 0);
        chk("rst_par",      bus.par_data, 0);

        // full frame 0x01..0x0D
        flag_cnt = 0;
        for (int i = 0; i < DP; i++) begin
            step(1, 8'(i + 1));
            if (i == 5)  chk("a_count6", bus.count, 6);
            if (i == 11) chk("a_noflag_early", bus.s_p_flag, 0);
        end
        chk("a_flag",     bus.s_p_flag, 1);
        chk("a_flag_cyc", 128'(last_flag), 128'(cyc));
        chk("a_count13",  bus.count, 13);
        chk("a_slot0",    bus.par_data[7:0], 8'h01);
        chk("a_slot12",   bus.par_data[12*DW +: DW], 8'h0D);
        chk("a_par",      bus.par_data, frame(8'h01));
        low = (bus.in_ready === 1'b0) ? 1 : 0;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            step(0, 8'h00);
            guard++;
            if (bus.in_ready === 1'b0) low++;
        end
        chk("a_ready_low_cycles", 128'(low), 128'(1 + HC));
        chk("a_ready_back", bus.in_ready, 1);
        chk("a_count_clear", bus.count, 0);
        chk("a_one_pulse", 128'(flag_cnt), 1);
        chk("a_par_kept", bus.par_data, frame(8'h01));

        // gapped input 0x30..0x3C, valid on alternate cycles
        flag_cnt = 0;
        start = cyc;
        for (int i = 0; i < 2*DP - 1; i++) begin
            step((i % 2) == 0, 8'(8'h30 + i/2));
            if (i == 1)  chk("b_count_gap", bus.count, 1);
            if (i == 23) begin
                chk("b_noflag_early", bus.s_p_flag, 0);
                chk("b_count12", bus.count, 12);
            end
        end
        chk("b_flag",     bus.s_p_flag, 1);
        chk("b_flag_cyc", 128'(last_flag - start), 25);
        chk("b_par",      bus.par_data, frame(8'h30));

        // in_valid held high with changing data through FLAG and HOLD
        for (int j = 0; j < 1 + HC; j++) begin
            step(1, 8'(8'hA0 + j));
            if (j == HC - 1) begin
                chk("c_count_hold", bus.count, 13);
                chk("c_ready_hold", bus.in_ready, 0);
                chk("c_par_hold",   bus.par_data, frame(8'h30));
            end
        end
        chk("c_ready_back", bus.in_ready, 1);
        chk("c_count_zero", bus.count, 0);
        chk("c_par_after",  bus.par_data, frame(8'h30));
        step(1, 8'hEE);
        chk("c_first_slot0", bus.par_data[7:0], 8'hEE);
        chk("c_slot1_old",   bus.par_data[15:8], 8'h31);
        chk("c_count1",      bus.count, 1);
        chk("c_no_extra_flag", 128'(flag_cnt), 1);

        // mid-frame reset after 7 accepts, with in_valid high during reset
        flag_cnt = 0;
        for (int i = 0; i < 6; i++) step(1, 8'(8'h50 + i));
        chk("d_count7",  bus.count, 7);
        chk("d_noflag7", 128'(flag_cnt), 0);
        rst = 1'b1;
        step(1, 8'h77);
        rst = 1'b0;
        chk("d_rst_count", bus.count, 0);
        chk("d_rst_par",   bus.par_data, 0);
        chk("d_rst_ready", bus.in_ready, 1);
        for (int i = 0; i < DP; i++) begin
            step(1, 8'(8'h40 + i));
            if (i == 11) begin
                chk("d_noflag12", bus.s_p_flag, 0);
                chk("d_count12",  bus.count, 12);
            end
        end
        chk("d_flag",  bus.s_p_flag, 1);
        chk("d_slot0", bus.par_data[7:0], 8'h40);
        chk("d_par",   bus.par_data, frame(8'h40));
        chk("d_flag_once", 128'(flag_cnt), 1);
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            step(0, 8'h00);
            guard++;
        end
        chk("d_drained", bus.in_ready, 1);

        // back-to-back frames; the driver registers in_ready and starts the cycle after seeing it high
        flag_cnt = 0;
        for (int i = 0; i < DP; i++) step(1, 8'(8'h10 + i));
        chk("e_flag1", bus.s_p_flag, 1);
        f1 = last_flag;
        chk("e_par1", bus.par_data, frame(8'h10));
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            step(0, 8'h00);
            guard++;
        end
        chk("e_ready_seen", bus.in_ready, 1);
        step(0, 8'h00);
        for (int i = 0; i < DP; i++) step(1, 8'(8'h20 + i));
        chk("e_flag2",   bus.s_p_flag, 1);
        chk("e_spacing", 128'(last_flag - f1), 23);
        chk("e_par2",    bus.par_data, frame(8'h20));
        chk("e_flags",   128'(flag_cnt), 2);
        bus.in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
